// File: rtl/ysyx_25040111_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// Optional response watchdog and ERR state: define MEM_ARBITER_TIMEOUT_EN.
module ysyx_25040111_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err,
    output logic                timeout_err
);
    localparam int MASK_W = DATA_W / 8;

`ifdef MEM_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
`endif

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = IFU, 1 = LSU
    logic                ptr_q, ptr_d;       // requester preferred on a tie
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                grant_ifu, grant_lsu;
    logic                owner_rsp_ready, rsp_hs, expire;

    // Requests are only granted out of reset, so req_ready stays low while reset is held.
    assign grant_ifu = (state_q == S_IDLE) && reset && ifu_req_valid && (!lsu_req_valid || !ptr_q);
    assign grant_lsu = (state_q == S_IDLE) && reset && lsu_req_valid && (!ifu_req_valid || ptr_q);
    assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;
    assign rsp_hs = (state_q == S_RESP) && mem_rsp_valid && owner_rsp_ready;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    assign expire = ((state_q == S_REQ) || (state_q == S_RESP && !rsp_hs))
                    && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ifu || grant_lsu)
            cnt_d = '0;
        else if (state_q == S_REQ || state_q == S_RESP)
            cnt_d = cnt_q + 1'b1;
        tmo_d = tmo_q | expire;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign expire = 1'b0;
    // Watchdog compiled out: the flag is a constant zero.
    assign timeout_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    state_d = S_REQ;
                    owner_d = grant_lsu;
                    ptr_d   = grant_ifu;   // pointer moves to the loser
                    addr_d  = grant_lsu ? lsu_addr : ifu_addr;
                    wen_d   = grant_lsu & lsu_wen;
                    wdata_d = grant_lsu ? lsu_wdata : '0;
                    wmask_d = grant_lsu ? lsu_wmask : '0;
                end
            end
            S_REQ: begin
                if (expire)             state_d = state_e'(2'd3);
                else if (mem_req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (expire)      state_d = state_e'(2'd3);
                else if (rsp_hs) state_d = S_IDLE;
            end
            default: begin
                if (owner_rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_data  = '0;
        lsu_rsp_err   = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        case (state_q)
            S_IDLE: begin
                mem_rsp_ready = 1'b1;   // drains stray/late responses
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
            end
            S_REQ: mem_req_valid = 1'b1;
            S_RESP: begin
                mem_rsp_ready = owner_rsp_ready;
                if (owner_q) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rsp_data  = mem_rsp_data;
                    lsu_rsp_err   = mem_rsp_err;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rsp_data  = mem_rsp_data;
                    ifu_rsp_err   = mem_rsp_err;
                end
            end
            default: begin
                if (owner_q) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_err   = 1'b1;
                end else begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_err   = 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Scoreboard bench for ysyx_25040111_mem_arbiter with a small in-bench memory model.
module tb_ysyx_25040111_mem_arbiter;
    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;
    typedef struct {
        logic        owner;
        logic        wen;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clock, reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [3:0]  mem_wmask;
    logic        timeout_err;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic        grant_log[$];
    int          n_chk = 0, n_fail = 0, n_ifu_rsp = 0, n_lsu_rsp = 0;
    logic        mem_pend = 0, mem_silent = 0, pend_err = 0;
    logic [31:0] pend_data = 0;

    ysyx_25040111_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // One clock: sample handshakes at the negedge, then update the memory model after the posedge.
    task automatic step();
        req_t e;
        rsp_t r;
        logic rsp_hs, req_hs;
        @(negedge clock);
        req_hs = 1'b0;
        if (reset) begin
            if (ifu_req_valid && ifu_req_ready) begin
                req_q.push_back('{1'b0, ifu_addr, 1'b0, 32'h0, 4'h0});
                grant_log.push_back(1'b0);
            end
            if (lsu_req_valid && lsu_req_ready) begin
                req_q.push_back('{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask});
                grant_log.push_back(1'b1);
            end
            if (mem_req_valid && mem_req_ready) begin
                req_hs = 1'b1;
                if (req_q.size() == 0) chk("mem_req_unexpected", 1, 0);
                else begin
                    e = req_q.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wen", mem_wen, e.wen);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("mem_wmask", mem_wmask, e.wmask);
                    rsp_q.push_back('{e.owner, e.wen, mem_silent ? 32'h0 : rd_model(e.addr),
                                      mem_silent ? 1'b1 : (e.addr[31:28] == 4'hF)});
                end
                pend_data = rd_model(mem_addr);
                pend_err  = (mem_addr[31:28] == 4'hF);
            end
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                n_ifu_rsp++;
                if (rsp_q.size() == 0) chk("ifu_rsp_unexpected", 1, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk("ifu_rsp_owner", 0, r.owner);
                    chk("ifu_rsp_err", ifu_rsp_err, r.err);
                    chk("ifu_rsp_data", ifu_rsp_data, r.data);
                end
            end
            if (lsu_rsp_valid && lsu_rsp_ready) begin
                n_lsu_rsp++;
                if (rsp_q.size() == 0) chk("lsu_rsp_unexpected", 1, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk("lsu_rsp_owner", 1, r.owner);
                    chk("lsu_rsp_err", lsu_rsp_err, r.err);
                    if (!r.wen) chk("lsu_rsp_data", lsu_rsp_data, r.data);
                end
            end
        end
        rsp_hs = reset && mem_rsp_valid && mem_rsp_ready;
        @(posedge clock);
        #1;
        if (rsp_hs) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            mem_rsp_err   = 1'b0;
        end
        if (req_hs && !mem_silent) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_data;
            mem_rsp_err   = pend_err;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0) && k < 100) begin
            step();
            k++;
        end
        chk("drain_bound", k < 100, 1);
    endtask

    task automatic req_ifu(input logic [31:0] a);
        int k = 0;
        ifu_req_valid = 1'b1;
        ifu_addr = a;
        #1;
        while (!ifu_req_ready && k < 50) begin
            step();
            #1;
            k++;
        end
        chk("ifu_grant_bound", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
    endtask

    task automatic req_lsu(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
        int k = 0;
        lsu_req_valid = 1'b1;
        lsu_addr = a;
        lsu_wen = w;
        lsu_wdata = d;
        lsu_wmask = m;
        #1;
        while (!lsu_req_ready && k < 50) begin
            step();
            #1;
            k++;
        end
        chk("lsu_grant_bound", lsu_req_ready, 1);
        step();
        lsu_req_valid = 1'b0;
    endtask

    initial begin
        int k, n0;
        reset = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 1;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;

        // Reset held three cycles
        repeat (3) step();
        #1;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_ifu_req_ready", ifu_req_ready, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;
        #1;
        chk("idle_mem_rsp_ready", mem_rsp_ready, 1);
        chk("idle_ifu_req_ready", ifu_req_ready, 0);
        step();

        // Simultaneous requests: IFU first, then strict alternation
        grant_log.delete();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
        #1;
        chk("tie_ifu_req_ready", ifu_req_ready, 1);
        chk("tie_lsu_req_ready", lsu_req_ready, 0);
        k = 0;
        while (grant_log.size() < 4 && k < 60) begin
            step();
            k++;
        end
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        chk("tie_grant_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_grant%0d", i), (i < grant_log.size()) ? {1'b0, grant_log[i]} : 2'd3, i % 2);
        drain();

        // IFU alone, zero-wait memory
        n0 = n_ifu_rsp;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        chk("solo_ifu_req_ready", ifu_req_ready, 1);
        chk("solo_lsu_req_ready", lsu_req_ready, 0);
        step();
        ifu_req_valid = 0;
        #1;
        chk("solo_mem_req_valid", mem_req_valid, 1);
        chk("solo_mem_addr", mem_addr, 32'h8000_0000);
        chk("solo_mem_wen", mem_wen, 0);
        step();
        #1;
        chk("solo_ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("solo_ifu_rsp_data", ifu_rsp_data, 32'hDEAD_BEEF);
        chk("solo_ifu_rsp_err", ifu_rsp_err, 0);
        chk("solo_lsu_rsp_valid", lsu_rsp_valid, 0);
        drain();
        chk("solo_ifu_rsp_cnt", n_ifu_rsp - n0, 1);

        // Error passthrough and a partial-mask write
        req_lsu(32'hF000_0010, 1'b0, 32'h0, 4'h0);
        drain();
        req_lsu(32'h8000_2004, 1'b1, 32'hCAFE_F00D, 4'h3);
        drain();

        // LSU read with request stall then response back-pressure; IFU waits meanwhile
        n0 = n_lsu_rsp;
        mem_req_ready = 0;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        #1;
        chk("stall_lsu_req_ready", lsu_req_ready, 1);
        step();
        lsu_req_valid = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_5000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_mem_req_valid", mem_req_valid, 1);
            chk("stall_mem_addr", mem_addr, 32'h8000_2000);
            chk("stall_mem_wen", mem_wen, 0);
            chk("stall_ifu_req_ready", ifu_req_ready, 0);
            step();
        end
        mem_req_ready = 1;
        #1;
        chk("stall_ifu_req_ready_hs", ifu_req_ready, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            lsu_rsp_ready = 0;
            #1;
            chk("bp_lsu_rsp_valid", lsu_rsp_valid, 1);
            chk("bp_lsu_rsp_data", lsu_rsp_data, rd_model(32'h8000_2000));
            chk("bp_mem_rsp_ready", mem_rsp_ready, 0);
            chk("bp_ifu_req_ready", ifu_req_ready, 0);
            chk("bp_ifu_rsp_valid", ifu_rsp_valid, 0);
            step();
        end
        lsu_rsp_ready = 1;
        #1;
        chk("bp_mem_rsp_ready_hi", mem_rsp_ready, 1);
        step();
        chk("bp_lsu_rsp_cnt", n_lsu_rsp - n0, 1);
        #1;
        chk("bp_lsu_rsp_valid_after", lsu_rsp_valid, 0);
        chk("bp_next_grant", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        drain();

        // Reset while a response is pending
        ifu_rsp_ready = 0;
        req_ifu(32'h8000_6000);
        step();
        #1;
        chk("rr_pre_ifu_rsp_valid", ifu_rsp_valid, 1);
        reset = 1'b0;
        #1;
        chk("rr_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rr_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rr_mem_req_valid", mem_req_valid, 0);
        req_q.delete();
        rsp_q.delete();
        step();
        step();
        ifu_rsp_ready = 1;
        reset = 1'b1;
        #1;
        chk("rr_stray_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rr_stray_mem_rsp_ready", mem_rsp_ready, 1);
        step();
        n0 = n_ifu_rsp;
        req_ifu(32'h8000_7000);
        drain();
        chk("rr_after_ifu_rsp_cnt", n_ifu_rsp - n0, 1);

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Memory accepts but never answers
        mem_silent = 1;
        req_ifu(32'h8000_8000);
        k = 0;
        #1;
        while (!ifu_rsp_valid && k < 40) begin
            step();
            #1;
            k++;
        end
        chk("to_latency_window", (k >= 15 && k <= 17), 1);
        chk("to_ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("to_ifu_rsp_err", ifu_rsp_err, 1);
        chk("to_ifu_rsp_data", ifu_rsp_data, 0);
        chk("to_mem_req_valid", mem_req_valid, 0);
        chk("to_mem_rsp_ready", mem_rsp_ready, 0);
        chk("to_flag", timeout_err, 1);
        step();
        mem_silent = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222; mem_rsp_err = 0;
        #1;
        chk("late_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("late_mem_rsp_ready", mem_rsp_ready, 1);
        step();
        step();
        chk("late_flag_sticky", timeout_err, 1);
        chk("late_queue_empty", rsp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25040111_mem_arbiter.md
Name: ysyx_25040111_mem_arbiter

Overview:
- Shares one memory/bus port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sits between the IFU/LSU and the SoC/SRAM bridge.
- Arbitrates with a round-robin policy and keeps exactly one transaction outstanding.
- Routes each response back to the requester that issued it.
- All channels use valid/ready handshakes; a transfer occurs on valid & ready at the posedge.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 255, response-watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets the block immediately, independent of clock.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_rsp_valid  out  1  IFU response valid.
- ifu_rsp_ready  in  1  IFU can take response.
- ifu_rsp_data  out  DATA_W  fetched word.
- ifu_rsp_err  out  1  bus/timeout error for IFU.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte-write mask.
- lsu_rsp_valid  out  1  LSU response valid.
- lsu_rsp_ready  in  1  LSU can take response.
- lsu_rsp_data  out  DATA_W  read data (don't-care for writes).
- lsu_rsp_err  out  1  bus/timeout error for LSU.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  registered address.
- mem_wen  out  1  registered write enable (0 for IFU).
- mem_wdata  out  DATA_W  registered write data (0 for IFU).
- mem_wmask  out  DATA_W/8  registered mask (0 for IFU).
- mem_rsp_valid  in  1  memory response.
- mem_rsp_ready  out  1  arbiter takes response.
- mem_rsp_data  in  DATA_W  response data.
- mem_rsp_err  in  1  memory error.
- timeout_err  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:

FSM states: IDLE, REQ, RESP, ERR (ERR exists only with the feature). Owner register: IFU/LSU. Priority pointer: next-preferred requester.

Reset (reset=0, asynchronous):
- State IDLE, pointer=IFU, owner=IFU.
- All request fields 0; timeout_err=0.
- Every valid/ready output is 0 except mem_rsp_ready, which is 1 in IDLE.
- Reset mid-transaction abandons the transaction with no response to either requester.
- mem_req_valid drops asynchronously.

IDLE:
- mem_rsp_ready=1; stray/late memory responses are consumed and discarded.
- If exactly one req_valid is high, that requester wins.
- If both are high, the pointer's requester wins.
- The winner's req_ready=1 combinationally in the same cycle. Addr/wen/wdata/wmask are latched into registers and owner is set. Next state is REQ.
- Pointer flips to the loser after every grant.
- The non-winner's req_ready=0.
- With no valids, stay in IDLE.

REQ:
- mem_req_valid=1 with the registered fields, held stable until mem_req_ready.
- Both req_ready=0.
- On handshake, go to RESP.

RESP:
- Owner's rsp_valid=mem_rsp_valid; rsp_data/rsp_err pass through combinationally.
- mem_rsp_ready=owner's rsp_ready.
- Non-owner rsp_valid=0.
- On handshake, go to IDLE.
- A new grant is possible the next cycle: minimum 3 cycles from acceptance to response with zero-wait memory.

Other rules:
- req_ready is never high outside IDLE.
- Requests are never reordered, duplicated or dropped except on reset or timeout.
- A requester holding valid keeps it until accepted. With both requesters continuously valid, grants alternate strictly.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.

Enabled:
- An 8..16-bit watchdog counter clears on entering REQ and increments each cycle in REQ/RESP.
- When it reaches TIMEOUT without the RESP handshake, the FSM goes to ERR and timeout_err is set (sticky until reset).
- In ERR: mem_req_valid=0 and mem_rsp_ready=0. Owner's rsp_valid=1, rsp_err=1, rsp_data=0, held until owner rsp_ready; then IDLE.
- A late memory response is discarded in IDLE.

Disabled:
- No counter or ERR state; the arbiter waits indefinitely.
- timeout_err is tied to 0.

Test Plan:
- Reset low 3 cycles, all inputs idle -> all valid/ready outputs 0, timeout_err=0. After release: mem_rsp_ready=1, ifu_req_ready=0 until a request arrives.
- IFU alone reads 0x80000000, memory ready and returns 0xDEADBEEF next cycle -> ifu_req_ready in cycle 0, mem_req_valid cycle 1 with addr 0x80000000, wen=0. ifu_rsp_valid cycle 2 with data 0xDEADBEEF, err=0.
- IFU and LSU valid together right after reset (LSU write 0x80001000, wdata 0x12345678, wmask 0xF) -> IFU granted first, LSU second. mem_wen=1, mask=0xF on LSU's transfer. With both held valid, grant order is IFU, LSU, IFU, LSU.
- LSU read with mem_req_ready low 4 cycles, then lsu_rsp_ready low 2 cycles during response -> mem_addr/mem_wen stable all 4 cycles. mem_rsp_ready mirrors lsu_rsp_ready. Response delivered once. ifu_req_ready stays 0 throughout.
- Reset asserted while in RESP with mem_rsp_valid pending -> outputs clear immediately with no rsp_valid to either side. Next IFU request after release completes normally.
- With MEM_ARBITER_TIMEOUT_EN and TIMEOUT=16, IFU request accepted but memory never responds -> at 16 cycles, ifu_rsp_valid=1, ifu_rsp_err=1, data 0, timeout_err=1 sticky. A late mem_rsp_valid is discarded in IDLE and does not reach IFU.
